// File: rtl/adc_scan_pkg.sv
// Shared types and elaboration helpers for the multi-channel ADC scan controller.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_DESELECT = 3'd4
  } scan_state_t;

  // Channel index width; a two-channel scan still needs one bit.
  function automatic int ch_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  // A frame must carry the start bit, the channel field and the full result.
  function automatic bit frame_fits(input int frame_w, input int ch_w, input int data_w);
    return frame_w >= (1 + ch_w + data_w);
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// One SPI mode-0 frame: drives cs_n/sck/mosi for a channel command and
// shifts the DATA_W-bit result in from miso. Strobes done in the cycle
// before the final sck fall, so cs_n rises on the same edge the parent
// leaves SHIFT.
module spi_frame_engine
  import adc_scan_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int DATA_W  = 12,
  parameter int SCK_DIV = 4,
  parameter int CH_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [CH_W-1:0]   ch,
  input  logic              miso,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] data
);

  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int HP_W  = $clog2(2 * FRAME_W);
  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(SCK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST   = HP_W'(2 * FRAME_W - 1);
  localparam logic [HP_W-2:0]  FIRST_IDX = (HP_W - 1)'(FRAME_W - DATA_W);

  logic               active;
  logic [DIV_W-1:0]   div_cnt;
  logic [HP_W-1:0]    hp_cnt;
  logic [HP_W-2:0]    bit_idx;
  logic [FRAME_W-1:0] cmd_sr;
  logic [FRAME_W-1:0] frame;
  logic               tick;

  assign bit_idx = hp_cnt[HP_W-1:1];
  assign tick    = active && (div_cnt == '0);
  assign done    = tick && (hp_cnt == HP_LAST);

  // Command word: start bit first, then the channel MSB first, rest zero.
  always_comb begin
    frame    = '0;
    frame[0] = 1'b1;
    for (int b = 0; b < CH_W; b++) begin
      frame[1 + b] = ch[CH_W - 1 - b];
    end
  end

  // Half-period down-counter; each terminal count toggles sck.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      hp_cnt  <= '0;
      cmd_sr  <= '0;
      data    <= '0;
    end else if (!active) begin
      if (go) begin
        active  <= 1'b1;
        cs_n    <= 1'b0;
        sck     <= 1'b0;
        mosi    <= frame[0];
        cmd_sr  <= frame;
        div_cnt <= DIV_LOAD;
        hp_cnt  <= '0;
      end
    end else if (!tick) begin
      div_cnt <= div_cnt - 1'b1;
    end else begin
      div_cnt <= DIV_LOAD;
      hp_cnt  <= hp_cnt + 1'b1;
      if (!hp_cnt[0]) begin
        sck <= 1'b1;
        if (bit_idx >= FIRST_IDX) begin
          data <= {data[DATA_W-2:0], miso};
        end
      end else begin
        sck    <= 1'b0;
        cmd_sr <= cmd_sr >> 1;
        mosi   <= cmd_sr[1];
        if (done) begin
          active <= 1'b0;
          cs_n   <= 1'b1;
          mosi   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_controller.sv
// Scans N_CH channels of a multiplexed SPI ADC, publishes each sample with
// its channel and keeps a hysteretic above-threshold flag per channel.
//
// state    | meaning
// IDLE     | waiting for start; cs_n high
// SELECT   | launch frame; cs_n falls on the next edge, first half-period follows
// SHIFT    | frame engine clocking command out and result in
// UPDATE   | cs_n already high; publish sample, update flag, pick next channel
// DESELECT | extra cs_n high time so the next fall is SCK_DIV after the rise
module adc_scan_controller
  import adc_scan_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter int SCK_DIV = 4,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] hyst,
  input  logic              miso,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic [N_CH-1:0]   above
);

  if (!frame_fits(FRAME_W, CH_W, DATA_W) || SCK_DIV < 2 || N_CH < 2 || N_CH > 16) begin : g_bad_cfg
    $error("adc_scan_controller: illegal N_CH/FRAME_W/SCK_DIV combination");
  end

  // UPDATE and SELECT already provide two of the SCK_DIV high cycles.
  localparam bit HAS_GAP = (SCK_DIV > 2);
  localparam int GAP_W   = $clog2(SCK_DIV);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HAS_GAP ? SCK_DIV - 3 : 0);

  scan_state_t       state, state_nxt;
  logic              go;
  logic              frame_done;
  logic [DATA_W-1:0] frame_data;
  logic [CH_W-1:0]   ch_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_ch;
  logic [DATA_W:0]   set_sum, clr_diff, set_lvl, samp_ext;
  logic              flag_nxt;

  assign last_ch = (ch_cnt == CH_W'(N_CH - 1));
  assign busy    = (state != ST_IDLE);

  spi_frame_engine #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W),
    .SCK_DIV (SCK_DIV),
    .CH_W    (CH_W)
  ) u_frame (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .ch    (ch_cnt),
    .miso  (miso),
    .cs_n  (cs_n),
    .sck   (sck),
    .mosi  (mosi),
    .done  (frame_done),
    .data  (frame_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and frame launch.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_SELECT;
      ST_SELECT: begin
        go        = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT:    if (frame_done) state_nxt = ST_UPDATE;
      ST_UPDATE: begin
        if (last_ch && !continuous) state_nxt = ST_IDLE;
        else if (HAS_GAP)           state_nxt = ST_DESELECT;
        else                        state_nxt = ST_SELECT;
      end
      ST_DESELECT: if (gap_cnt == '0) state_nxt = ST_SELECT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Hysteresis levels in DATA_W+1 bits: set saturates, clear floors at zero
  // (a floored clear level can never be undercut, so the flag then only sets).
  always_comb begin
    set_sum  = {1'b0, threshold} + {1'b0, hyst};
    clr_diff = {1'b0, threshold} - {1'b0, hyst};
    set_lvl  = set_sum[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : set_sum;
    samp_ext = {1'b0, frame_data};
    flag_nxt = above[ch_cnt];
    if (samp_ext >= set_lvl)                         flag_nxt = 1'b1;
    else if (!clr_diff[DATA_W] && samp_ext < clr_diff) flag_nxt = 1'b0;
  end

  // Sample publication, flag registers, channel sequencing and cs_n gap timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      above        <= '0;
      ch_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_UPDATE: begin
          sample_valid  <= 1'b1;
          sample_data   <= frame_data;
          sample_ch     <= ch_cnt;
          above[ch_cnt] <= flag_nxt;
          ch_cnt        <= last_ch ? '0 : ch_cnt + 1'b1;
          gap_cnt       <= GAP_LOAD;
        end
        ST_DESELECT: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Directed bench for adc_scan_controller with a behavioural multiplexed SPI ADC.
module tb_adc_scan_controller;

  logic        clk = 1'b0;
  logic        reset, start, continuous, miso;
  logic [11:0] threshold, hyst;
  logic        cs_n, sck, mosi, busy, sample_valid;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;
  logic [3:0]  above;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [11:0] adc_val [4];
  logic [15:0] frame_q [$];
  logic [11:0] sv_data [$];
  logic [1:0]  sv_ch   [$];
  int          sv_cyc  [$];

  adc_scan_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .threshold    (threshold),
    .hyst         (hyst),
    .miso         (miso),
    .cs_n         (cs_n),
    .sck          (sck),
    .mosi         (mosi),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .above        (above)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ADC model: decodes the command on sck rises, presents result bits after falls.
  initial begin : adc_model
    int          idx;
    logic [15:0] rx;
    logic [1:0]  mch;
    logic        sck_q;
    idx = 0; rx = '0; mch = '0; sck_q = 1'b0; miso = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_n) begin
        idx  = 0;
        miso = 1'b0;
      end else if (sck && !sck_q) begin
        rx[idx] = mosi;
        if (idx == 2) mch = {rx[1], rx[2]};
        idx++;
        if (idx == 16) frame_q.push_back(rx);
      end else if (!sck && sck_q && idx >= 4 && idx < 16) begin
        miso = adc_val[mch][15 - idx];
      end
      sck_q = sck;
    end
  end

  initial begin : sample_log
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        sv_data.push_back(sample_data);
        sv_ch.push_back(sample_ch);
        sv_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    frame_q.delete(); sv_data.delete(); sv_ch.delete(); sv_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("scan_done_in_time", 32'(busy), 0);
  endtask

  task automatic run_scan();
    pulse_start();
    wait_idle(1000);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int          c, n, n0;
    logic [15:0] exp_frame [4];
    logic [11:0] hy_val [4];
    logic        hy_exp [4];
    exp_frame = '{16'h0001, 16'h0005, 16'h0003, 16'h0007};
    hy_val    = '{12'h805, 12'h810, 12'h7F5, 12'h7EF};
    hy_exp    = '{1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    threshold = 12'h800; hyst = 12'h010;
    for (int i = 0; i < 4; i++) adc_val[i] = 12'hA5A + 12'(i);

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", 32'(cs_n), 1);
    check_eq("rst_sck", 32'(sck), 0);
    check_eq("rst_mosi", 32'(mosi), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(sample_valid), 0);
    check_eq("rst_data", 32'(sample_data), 0);
    check_eq("rst_ch", 32'(sample_ch), 0);
    check_eq("rst_above", 32'(above), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single scan with latency checks
    clear_logs();
    c = cyc;
    pulse_start();
    check_eq("busy_after_start", 32'(busy), 1);
    check_eq("cs_n_high_at_k", 32'(cs_n), 1);
    @(negedge clk);
    check_eq("cs_n_low_k1", 32'(cs_n), 0);
    check_eq("mosi_start_bit", 32'(mosi), 1);
    wait_idle(1000);
    check_eq("scan_count", 32'(sv_data.size()), 4);
    check_eq("frame_count", 32'(frame_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sv_data.size()) begin
        check_eq($sformatf("scan_data_%0d", i), 32'(sv_data[i]), 32'(12'hA5A + 12'(i)));
        check_eq($sformatf("scan_ch_%0d", i), 32'(sv_ch[i]), 32'(i));
      end
      if (i < frame_q.size()) check_eq($sformatf("mosi_frame_%0d", i), 32'(frame_q[i]), 32'(exp_frame[i]));
    end
    if (sv_cyc.size() >= 2) begin
      check_eq("first_valid_k130", 32'(sv_cyc[0] - c), 131);
      check_eq("channel_period", 32'(sv_cyc[1] - sv_cyc[0]), 132);
    end
    check_eq("scan_above", 32'(above), 4'hF);

    // Hysteresis on channel 0
    apply_reset();
    threshold = 12'h800; hyst = 12'h010;
    for (int i = 0; i < 4; i++) begin
      adc_val[0] = hy_val[i];
      run_scan();
      check_eq($sformatf("hyst_%0d", i), 32'(above[0]), 32'(hy_exp[i]));
    end

    // Saturated set level, then a floored clear level
    threshold = 12'hFF8; hyst = 12'h010;
    adc_val[0] = 12'hFFE; run_scan();
    check_eq("sat_fffe", 32'(above[0]), 0);
    adc_val[0] = 12'hFFF; run_scan();
    check_eq("sat_ffff", 32'(above[0]), 1);
    threshold = 12'h005; hyst = 12'h010;
    adc_val[0] = 12'h000; run_scan();
    check_eq("floor_holds", 32'(above[0]), 1);
    adc_val[0] = 12'hA5A;

    // Continuous: two full passes, drop during ch 1 of pass 3
    clear_logs();
    continuous = 1'b1;
    pulse_start();
    n = 0;
    while (sv_ch.size() < 9 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cont_reached_pass3", 32'(sv_ch.size() >= 9), 1);
    continuous = 1'b0;
    wait_idle(2000);
    check_eq("cont_count", 32'(sv_ch.size()), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < sv_ch.size()) check_eq($sformatf("cont_ch_%0d", i), 32'(sv_ch[i]), 32'(i % 4));
    end

    // Start while busy is ignored
    clear_logs();
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle(1000);
    repeat (200) @(negedge clk);
    check_eq("busy_start_idle", 32'(busy), 0);
    check_eq("busy_start_count", 32'(sv_data.size()), 4);
    check_eq("busy_start_frames", 32'(frame_q.size()), 4);
    clear_logs();
    run_scan();
    check_eq("restart_count", 32'(sv_ch.size()), 4);
    if (sv_ch.size() > 0) check_eq("restart_first_ch", 32'(sv_ch[0]), 0);
    if (frame_q.size() > 0) check_eq("restart_first_frame", 32'(frame_q[0]), 32'(16'h0001));

    // Reset mid-frame
    clear_logs();
    pulse_start();
    repeat (60) @(negedge clk);
    check_eq("midframe_cs_n", 32'(cs_n), 0);
    n0 = sv_data.size();
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_cs_n", 32'(cs_n), 1);
    check_eq("abort_sck", 32'(sck), 0);
    check_eq("abort_mosi", 32'(mosi), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_valid", 32'(sample_valid), 0);
    repeat (2) @(negedge clk);
    check_eq("abort_data", 32'(sample_data), 0);
    check_eq("abort_ch", 32'(sample_ch), 0);
    check_eq("abort_above", 32'(above), 0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("abort_no_valid", 32'(sv_data.size() - n0), 0);
    check_eq("abort_stays_idle", 32'(cs_n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
